// File: rtl/parity_pkg.sv
// Shared widths, nibble type and parity helper for the parity generator/checker pair.
package parity_pkg;
  localparam int DATA_W_DEF    = 4;
  localparam int DEPTH_DEF     = 4;
  localparam int ERR_CNT_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] nibble_t;

  function automatic logic calc_parity(input logic [DATA_W_DEF-1:0] data);
    return ^data;
  endfunction
endpackage

// File: rtl/nibble_parity_checker_if.sv
// Upstream valid/ready word channel and downstream show-ahead FIFO head.
interface nibble_parity_checker_if #(parameter int DATA_W = 4);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output in_valid, in_data, in_parity, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, in_parity, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/nibble_parity_checker_fifo.sv
// Show-ahead FIFO: registered pointers/level, head presented combinationally (0 when empty).
module nibble_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: reads of unwritten slots are masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/nibble_parity_checker.sv
// Parity checker: good words go to the FIFO, bad words are dropped and counted.
module nibble_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  nibble_parity_checker_if.slave   bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_pulse,
  output logic                     err_sticky,
  output logic [ERR_CNT_W-1:0]     err_count,
  input  logic                     clr_err
);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic rdy_en, full, empty, exp_par, accept, good, bad;

  generate
    if (DATA_W == DATA_W_DEF) begin : g_pkg_par
      assign exp_par = calc_parity(bus.in_data);
    end else begin : g_gen_par
      assign exp_par = ^bus.in_data;
    end
  endgenerate

  // rdy_en keeps in_ready low through reset and up to the first edge after it.
  assign bus.in_ready = rdy_en && !full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign good         = (bus.in_parity == exp_par);
  assign bad          = accept && !good;
  assign bus.out_valid = !empty;

  nibble_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && good),
    .push_data (bus.in_data),
    .pop       (bus.out_ready),
    .pop_data  (bus.out_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      rdy_en    <= 1'b1;
      err_pulse <= bad;
      // A bad word in the same cycle as clr_err restarts the count at 1.
      if (bad) begin
        err_sticky <= 1'b1;
        if (clr_err)                err_count <= ERR_CNT_W'(1);
        else if (err_count != CNT_MAX) err_count <= err_count + ERR_CNT_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end
    end
  end
endmodule
